// File: rtl/mips_run_pkg.sv
// mips_run_pkg: run-controller state encoding, count width and state-to-output decode.
package mips_run_pkg;
    localparam int CNT_W = 32;
    typedef enum logic [2:0] {IDLE, RESET, CHECK, RUN, END} run_state_t;
    // {cpu_reset, cpu_clk_enable, busy} for a given state
    function automatic logic [2:0] state_outs(run_state_t s);
        return {s == IDLE || s == RESET, s == RESET || s == CHECK || s == RUN,
                s == RESET || s == CHECK || s == RUN};
    endfunction
endpackage

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: resets, launches and times out a CPU run, capturing register_v0.
// Define MIPS_RUN_FETCH_COUNT_EN to add the instr_read fetch counter.
module mips_run_ctrl
    import mips_run_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 40,
    parameter int unsigned RESET_CYCLES   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             active,
    input  logic [CNT_W-1:0] register_v0,
`ifdef MIPS_RUN_FETCH_COUNT_EN
    input  logic             instr_read,
    output logic [CNT_W-1:0] fetch_count,
`endif
    output logic             cpu_reset,
    output logic             cpu_clk_enable,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic             start_err,
    output logic [CNT_W-1:0] result,
    output logic [CNT_W-1:0] cycle_count
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
    run_state_t state, state_nxt;
    logic [CNT_W-1:0] rst_cnt;
    logic limit_hit;
    assign limit_hit = cycle_count == LIMIT - 1;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, END: state_nxt = start ? RESET : state;
            RESET:     state_nxt = rst_cnt <= 1 ? CHECK : RESET;
            CHECK:     state_nxt = active ? RUN : END;
            RUN:       state_nxt = !active || limit_hit ? END : RUN;
            default:   state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            {cpu_reset, cpu_clk_enable, busy} <= state_outs(IDLE);
            {done, timed_out, start_err} <= '0;
            result <= '0;
            cycle_count <= '0;
            rst_cnt <= '0;
`ifdef MIPS_RUN_FETCH_COUNT_EN
            fetch_count <= '0;
`endif
        end else begin
            state <= state_nxt;
            {cpu_reset, cpu_clk_enable, busy} <= state_outs(state_nxt);
            case (state)
                IDLE, END: if (start) begin
                    {done, timed_out, start_err} <= '0;
                    result <= '0;
                    cycle_count <= '0;
                    rst_cnt <= CNT_W'(RESET_CYCLES);
`ifdef MIPS_RUN_FETCH_COUNT_EN
                    fetch_count <= '0;
`endif
                end
                RESET: rst_cnt <= rst_cnt - 1;
                CHECK: start_err <= !active;
                RUN: begin
                    // completion takes priority over the limit on the same cycle
                    if (!active) begin
                        result <= register_v0;
                        done <= 1'b1;
                    end else if (limit_hit) begin
                        timed_out <= 1'b1;
                        cycle_count <= LIMIT;
                    end else begin
                        cycle_count <= cycle_count + 1;
                    end
`ifdef MIPS_RUN_FETCH_COUNT_EN
                    if (instr_read) fetch_count <= fetch_count + 1;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb_mips_run_ctrl: directed runs on three controller configurations with a result scoreboard.
module tb_mips_run_ctrl;
    logic clk = 0;
    logic rst = 1;
    logic active = 0;
    logic [31:0] v0 = 0;
    logic [2:0] start = 0;
    logic [2:0] cpu_reset, cpu_clk_enable, busy, done, timed_out, start_err;
    logic [31:0] result [3];
    logic [31:0] cycle_count [3];
    logic [31:0] fetch_count [3];
    int checks = 0;
    int errors = 0;
    int k;
`ifdef MIPS_RUN_FETCH_COUNT_EN
    logic instr_read = 0;
`else
    assign fetch_count[0] = 0;
    assign fetch_count[1] = 0;
    assign fetch_count[2] = 0;
`endif

    typedef struct {
        logic d, t, s;
        logic [31:0] r, c, f;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    mips_run_ctrl #(.TIMEOUT_CYCLES(40), .RESET_CYCLES(1)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .active(active), .register_v0(v0),
`ifdef MIPS_RUN_FETCH_COUNT_EN
        .instr_read(instr_read), .fetch_count(fetch_count[0]),
`endif
        .cpu_reset(cpu_reset[0]), .cpu_clk_enable(cpu_clk_enable[0]), .busy(busy[0]),
        .done(done[0]), .timed_out(timed_out[0]), .start_err(start_err[0]),
        .result(result[0]), .cycle_count(cycle_count[0]));
    mips_run_ctrl #(.TIMEOUT_CYCLES(8), .RESET_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .active(active), .register_v0(v0),
`ifdef MIPS_RUN_FETCH_COUNT_EN
        .instr_read(instr_read), .fetch_count(fetch_count[1]),
`endif
        .cpu_reset(cpu_reset[1]), .cpu_clk_enable(cpu_clk_enable[1]), .busy(busy[1]),
        .done(done[1]), .timed_out(timed_out[1]), .start_err(start_err[1]),
        .result(result[1]), .cycle_count(cycle_count[1]));
    mips_run_ctrl #(.TIMEOUT_CYCLES(40), .RESET_CYCLES(3)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .active(active), .register_v0(v0),
`ifdef MIPS_RUN_FETCH_COUNT_EN
        .instr_read(instr_read), .fetch_count(fetch_count[2]),
`endif
        .cpu_reset(cpu_reset[2]), .cpu_clk_enable(cpu_clk_enable[2]), .busy(busy[2]),
        .done(done[2]), .timed_out(timed_out[2]), .start_err(start_err[2]),
        .result(result[2]), .cycle_count(cycle_count[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input int idx);
        chk("rst_cpu_reset", 32'(cpu_reset[idx]), 1);
        chk("rst_clk_en", 32'(cpu_clk_enable[idx]), 0);
        chk("rst_busy", 32'(busy[idx]), 0);
        chk("rst_done", 32'(done[idx]), 0);
        chk("rst_timed_out", 32'(timed_out[idx]), 0);
        chk("rst_start_err", 32'(start_err[idx]), 0);
        chk("rst_result", result[idx], 0);
        chk("rst_cycle_count", cycle_count[idx], 0);
        chk("rst_fetch_count", fetch_count[idx], 0);
    endtask

    // pulse start, verify RESET entry, then wait for cpu_reset release (returns RESET cycles seen)
    task automatic start_run(input int idx, output int n);
        start[idx] = 1;
        tick();
        start[idx] = 0;
        chk("start_busy", 32'(busy[idx]), 1);
        chk("start_cpu_reset", 32'(cpu_reset[idx]), 1);
        chk("start_clk_en", 32'(cpu_clk_enable[idx]), 1);
        chk("start_done_clr", 32'(done[idx]), 0);
        n = 0;
        while (cpu_reset[idx] && n < 20) begin
            tick();
            n++;
        end
    endtask

    // CHECK sees active=1, then active stays high for n RUN cycles
    task automatic run_body(input int idx, input int n, input logic [15:0] pat);
        active = 1;
        tick();
        for (int i = 0; i < 100; i++) begin
            active = i < n;
`ifdef MIPS_RUN_FETCH_COUNT_EN
            instr_read = i < 16 && i < n ? pat[i] : 1'b0;
`endif
            tick();
            if (!busy[idx]) break;
        end
        active = 0;
`ifdef MIPS_RUN_FETCH_COUNT_EN
        instr_read = 0;
`endif
        chk("run_ended", 32'(busy[idx]), 0);
    endtask

    task automatic check_end(input int idx);
        exp_t e;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'(q.size()), 1);
            return;
        end
        e = q.pop_front();
        chk("end_done", 32'(done[idx]), 32'(e.d));
        chk("end_timed_out", 32'(timed_out[idx]), 32'(e.t));
        chk("end_start_err", 32'(start_err[idx]), 32'(e.s));
        chk("end_result", result[idx], e.r);
        chk("end_cycle_count", cycle_count[idx], e.c);
        chk("end_clk_en", 32'(cpu_clk_enable[idx]), 0);
        chk("end_cpu_reset", 32'(cpu_reset[idx]), 0);
        chk("end_busy", 32'(busy[idx]), 0);
`ifdef MIPS_RUN_FETCH_COUNT_EN
        chk("end_fetch_count", fetch_count[idx], e.f);
`endif
    endtask

    initial begin
        tick();
        tick();
        rst = 0;
        chk_reset(0);
        chk_reset(1);
        // timeout: active stuck high on the 8-cycle limit
        v0 = 32'h1111_2222;
        q.push_back('{d: 0, t: 1, s: 0, r: 0, c: 8, f: 0});
        start_run(1, k);
        chk("t_reset_cycles", k, 1);
        run_body(1, 1000, 16'h0000);
        check_end(1);
        // tie: active falls exactly on the limit cycle
        v0 = 32'hDEAD_BEEF;
        q.push_back('{d: 1, t: 0, s: 0, r: 32'hDEAD_BEEF, c: 7, f: 0});
        start_run(1, k);
        run_body(1, 7, 16'h0000);
        check_end(1);
        // normal run of 10 cycles with 6 fetches
        v0 = 32'h0000_0005;
        q.push_back('{d: 1, t: 0, s: 0, r: 5, c: 10, f: 6});
        start_run(0, k);
        chk("n_reset_cycles", k, 1);
        run_body(0, 10, 16'b10_1100_1101);
        check_end(0);
        // start failure: active never rises
        q.push_back('{d: 0, t: 0, s: 1, r: 0, c: 0, f: 0});
        start_run(0, k);
        active = 0;
        tick();
        tick();
        check_end(0);
        // rst mid-RUN with an ignored start pulse
        start_run(2, k);
        chk("r_reset_cycles_a", k, 3);
        active = 1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        chk("r_count_pre", cycle_count[2], 3);
        start[2] = 1;
        tick();
        start[2] = 0;
        chk("r_start_ignored_busy", 32'(busy[2]), 1);
        chk("r_start_ignored_cpu_reset", 32'(cpu_reset[2]), 0);
        chk("r_start_ignored_clk_en", 32'(cpu_clk_enable[2]), 1);
        chk("r_start_ignored_count", cycle_count[2], 4);
        tick();
        rst = 1;
        tick();
        rst = 0;
        active = 0;
        chk_reset(2);
        v0 = 32'h0000_1234;
        q.push_back('{d: 1, t: 0, s: 0, r: 32'h1234, c: 4, f: 4});
        start_run(2, k);
        chk("r_reset_cycles_b", k, 3);
        run_body(2, 4, 16'h000F);
        check_end(2);
        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
